// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS main control FSM and its datapath.
// master: the control FSM (consumes Opcode/MemReady, drives every control strobe).
// slave : the datapath side (drives Opcode/MemReady, consumes the control strobes).
interface multicycle_control_if;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 4;
    localparam int unsigned STATE_W  = 4;

    logic [OPCODE_W-1:0] Opcode;
    logic                MemReady;

    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemToReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          PCSource;
    logic                SignExtend;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                InstrDone;
    logic                MemTimeout;
    logic [STATE_W-1:0]  State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               SignExtend, ALUOp, InstrDone, MemTimeout, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               SignExtend, ALUOp, InstrDone, MemTimeout, State
    );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath. Sequences the shared ALU,
// unified memory, IR and register file over 3-5 states per instruction, with a
// MemReady wait-state handshake and a sticky watchdog on stalled memory cycles.
// Ports:
//   CLK      - clock, rising edge
//   Reset_L  - synchronous active-low reset; also forces every output to 0
//   bus      - multicycle_control_if.master: Opcode/MemReady in, control strobes,
//              InstrDone, MemTimeout and debug State out
// Parameter: MEM_WAIT_MAX (1..255) stalled memory cycles before MemTimeout sets.
// Build option: define MC_ILLEGAL_TRAP_EN to send unknown opcodes to a TRAP state
// that holds until reset; otherwise unknown opcodes retire as a 2-cycle NOP.
module multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                 CLK,
    input  logic                 Reset_L,
    multicycle_control_if.master bus
);

    localparam int unsigned CNT_W = 8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;

    logic               imm_valid;
    logic [3:0]         imm_aluop;
    logic               imm_sext;
    logic               in_wait;

    // State, watchdog counter and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // ALU-immediate decode; shared by DECODE dispatch and the IEXEC/IWB outputs.
    always_comb begin
        imm_valid = 1'b1;
        imm_aluop = ALU_ADD;
        imm_sext  = 1'b0;
        case (bus.Opcode)
            OP_ORI:   imm_aluop = ALU_OR;
            OP_ADDI:  begin imm_aluop = ALU_ADD; imm_sext = 1'b1; end
            OP_ADDIU: imm_aluop = ALU_ADDU;
            OP_ANDI:  imm_aluop = ALU_AND;
            OP_LUI:   imm_aluop = ALU_LUI;
            OP_SLTI:  begin imm_aluop = ALU_SLT; imm_sext = 1'b1; end
            OP_SLTIU: imm_aluop = ALU_SLTU;
            OP_XORI:  imm_aluop = ALU_XOR;
            default:  imm_valid = 1'b0;
        endcase
    end

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    // Next state, watchdog and control outputs.
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = '0;
        mem_timeout_d   = mem_timeout_q;

        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.SignExtend  = 1'b0;
        bus.ALUOp       = ALU_AND;
        bus.InstrDone   = 1'b0;
        bus.MemTimeout  = mem_timeout_q;
        bus.State       = state_q;

        // Count consecutive stalled memory cycles, saturating at the limit.
        if (in_wait && !bus.MemReady) begin
            if (wait_cnt_q >= CNT_W'(MEM_WAIT_MAX)) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            if (wait_cnt_d == CNT_W'(MEM_WAIT_MAX)) begin
                mem_timeout_d = 1'b1;
            end
        end

        case (state_q)
            S_FETCH: begin
                bus.MemRead  = 1'b1;
                bus.ALUSrcB  = 2'b01;
                bus.ALUOp    = ALU_ADD;
                bus.IRWrite  = bus.MemReady;
                bus.PCWrite  = bus.MemReady;
                if (bus.MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.SignExtend = 1'b1;
                bus.ALUOp      = ALU_ADD;
                if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (bus.Opcode == OP_RTYPE) begin
                    state_d = S_REXEC;
                end else if (bus.Opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (bus.Opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (imm_valid) begin
                    state_d = S_IEXEC;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    // Unknown opcode retires here as a NOP.
                    state_d       = S_FETCH;
                    bus.InstrDone = 1'b1;
`endif
                end
            end
            S_MEMADR: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.SignExtend = 1'b1;
                bus.ALUOp      = ALU_ADD;
                state_d        = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegWrite  = 1'b1;
                bus.MemToReg  = 1'b1;
                bus.InstrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite  = 1'b1;
                bus.IorD      = 1'b1;
                bus.InstrDone = bus.MemReady;
                if (bus.MemReady) state_d = S_FETCH;
            end
            S_REXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNC;
                state_d     = S_RWB;
            end
            S_RWB: begin
                // ALUOp held from REXEC so the result stays stable during writeback.
                bus.ALUOp     = ALU_FUNC;
                bus.RegWrite  = 1'b1;
                bus.RegDst    = 1'b1;
                bus.InstrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_IEXEC: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUOp      = imm_aluop;
                bus.SignExtend = imm_sext;
                state_d        = S_IWB;
            end
            S_IWB: begin
                bus.ALUOp      = imm_aluop;
                bus.SignExtend = imm_sext;
                bus.RegWrite   = 1'b1;
                bus.InstrDone  = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.InstrDone   = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite   = 1'b1;
                bus.PCSource  = 2'b10;
                bus.InstrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset masks every output immediately, before the clock edge lands.
        if (!Reset_L) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.IorD        = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.MemToReg    = 1'b0;
            bus.RegDst      = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.ALUSrcA     = 1'b0;
            bus.ALUSrcB     = 2'b00;
            bus.PCSource    = 2'b00;
            bus.SignExtend  = 1'b0;
            bus.ALUOp       = 4'b0000;
            bus.InstrDone   = 1'b0;
            bus.MemTimeout  = 1'b0;
            bus.State       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MEM_WAIT_MAX = 15).
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .CLK     (clk),
        .Reset_L (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle outputs.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_no_enables(input string tag);
        check({tag, "_pcw"},  8'(bus.PCWrite),     8'd0);
        check({tag, "_pcwc"}, 8'(bus.PCWriteCond), 8'd0);
        check({tag, "_mrd"},  8'(bus.MemRead),     8'd0);
        check({tag, "_mwr"},  8'(bus.MemWrite),    8'd0);
        check({tag, "_irw"},  8'(bus.IRWrite),     8'd0);
        check({tag, "_rw"},   8'(bus.RegWrite),    8'd0);
        check({tag, "_done"}, 8'(bus.InstrDone),   8'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.Opcode   = 6'b000000;
        bus.MemReady = 1'b1;

        // Power-on reset: MemReady high must not leak through to IRWrite/PCWrite.
        cyc();
        cyc();
        settle();
        check("rst_state", 8'(bus.State), 8'd0);
        check("rst_tmo", 8'(bus.MemTimeout), 8'd0);
        check_no_enables("rst");

        // Release: FETCH with MemReady high.
        rst_n = 1'b1;
        bus.Opcode = 6'b000000;
        settle();
        check("fetch_state", 8'(bus.State), 8'd0);
        check("fetch_mrd", 8'(bus.MemRead), 8'd1);
        check("fetch_iord", 8'(bus.IorD), 8'd0);
        check("fetch_irw", 8'(bus.IRWrite), 8'd1);
        check("fetch_pcw", 8'(bus.PCWrite), 8'd1);
        check("fetch_srcb", 8'(bus.ALUSrcB), 8'd1);
        check("fetch_aluop", 8'(bus.ALUOp), 8'h2);
        check("fetch_done", 8'(bus.InstrDone), 8'd0);

        // R-type: 0,1,6,7,0
        cyc(); settle();
        check("r_dec_state", 8'(bus.State), 8'd1);
        check("r_dec_srcb", 8'(bus.ALUSrcB), 8'd3);
        check("r_dec_sext", 8'(bus.SignExtend), 8'd1);
        check("r_dec_done", 8'(bus.InstrDone), 8'd0);
        cyc(); settle();
        check("r_exec_state", 8'(bus.State), 8'd6);
        check("r_exec_aluop", 8'(bus.ALUOp), 8'hF);
        check("r_exec_srca", 8'(bus.ALUSrcA), 8'd1);
        check("r_exec_done", 8'(bus.InstrDone), 8'd0);
        cyc(); settle();
        check("r_wb_state", 8'(bus.State), 8'd7);
        check("r_wb_rw", 8'(bus.RegWrite), 8'd1);
        check("r_wb_rd", 8'(bus.RegDst), 8'd1);
        check("r_wb_m2r", 8'(bus.MemToReg), 8'd0);
        check("r_wb_aluop", 8'(bus.ALUOp), 8'hF);
        check("r_wb_done", 8'(bus.InstrDone), 8'd1);
        bus.Opcode = 6'b100011;
        cyc(); settle();
        check("r_back_state", 8'(bus.State), 8'd0);
        check("r_back_done", 8'(bus.InstrDone), 8'd0);

        // LW with three stalled cycles in MEMRD.
        cyc(); settle();
        check("lw_dec_state", 8'(bus.State), 8'd1);
        cyc(); settle();
        check("lw_adr_state", 8'(bus.State), 8'd2);
        check("lw_adr_srca", 8'(bus.ALUSrcA), 8'd1);
        check("lw_adr_srcb", 8'(bus.ALUSrcB), 8'd2);
        check("lw_adr_sext", 8'(bus.SignExtend), 8'd1);
        cyc();
        bus.MemReady = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            check("lw_rd_state", 8'(bus.State), 8'd3);
            check("lw_rd_mrd", 8'(bus.MemRead), 8'd1);
            check("lw_rd_iord", 8'(bus.IorD), 8'd1);
            if (i < 3) begin
                cyc();
                if (i == 2) bus.MemReady = 1'b1;
                settle();
            end
        end
        cyc(); settle();
        check("lw_wb_state", 8'(bus.State), 8'd4);
        check("lw_wb_rw", 8'(bus.RegWrite), 8'd1);
        check("lw_wb_m2r", 8'(bus.MemToReg), 8'd1);
        check("lw_wb_rd", 8'(bus.RegDst), 8'd0);
        check("lw_wb_done", 8'(bus.InstrDone), 8'd1);
        check("lw_wb_tmo", 8'(bus.MemTimeout), 8'd0);
        cyc(); settle();
        check("lw_back_state", 8'(bus.State), 8'd0);

        // Reset in the middle of an LW (in MEMRD) held over two edges.
        cyc(); cyc(); cyc(); settle();
        check("lw2_rd_state", 8'(bus.State), 8'd3);
        rst_n = 1'b0;
        settle();
        check("mid_rst_state_comb", 8'(bus.State), 8'd0);
        check_no_enables("mid_rst_comb");
        cyc(); cyc(); settle();
        check("mid_rst_state", 8'(bus.State), 8'd0);
        check_no_enables("mid_rst");
        rst_n = 1'b1;
        bus.Opcode = 6'b101011;
        settle();
        check("mid_rel_mrd", 8'(bus.MemRead), 8'd1);
        check("mid_rel_iord", 8'(bus.IorD), 8'd0);
        check("mid_rel_state", 8'(bus.State), 8'd0);

        // SW: 0,1,2,5,0
        cyc(); cyc(); cyc(); settle();
        check("sw_wr_state", 8'(bus.State), 8'd5);
        check("sw_wr_mwr", 8'(bus.MemWrite), 8'd1);
        check("sw_wr_iord", 8'(bus.IorD), 8'd1);
        check("sw_wr_mrd", 8'(bus.MemRead), 8'd0);
        check("sw_wr_done", 8'(bus.InstrDone), 8'd1);
        bus.Opcode = 6'b001000;
        cyc(); settle();
        check("sw_back_state", 8'(bus.State), 8'd0);

        // ADDI: sign-extended ADD.
        cyc(); cyc(); settle();
        check("addi_ex_state", 8'(bus.State), 8'd8);
        check("addi_ex_aluop", 8'(bus.ALUOp), 8'h2);
        check("addi_ex_sext", 8'(bus.SignExtend), 8'd1);
        check("addi_ex_srcb", 8'(bus.ALUSrcB), 8'd2);
        cyc(); settle();
        check("addi_wb_state", 8'(bus.State), 8'd9);
        check("addi_wb_rw", 8'(bus.RegWrite), 8'd1);
        check("addi_wb_rd", 8'(bus.RegDst), 8'd0);
        check("addi_wb_aluop", 8'(bus.ALUOp), 8'h2);
        check("addi_wb_sext", 8'(bus.SignExtend), 8'd1);
        check("addi_wb_done", 8'(bus.InstrDone), 8'd1);
        bus.Opcode = 6'b001100;
        cyc();

        // ANDI: zero-extended AND.
        cyc(); cyc(); settle();
        check("andi_ex_state", 8'(bus.State), 8'd8);
        check("andi_ex_aluop", 8'(bus.ALUOp), 8'h0);
        check("andi_ex_sext", 8'(bus.SignExtend), 8'd0);
        cyc(); settle();
        check("andi_wb_rw", 8'(bus.RegWrite), 8'd1);
        check("andi_wb_rd", 8'(bus.RegDst), 8'd0);
        check("andi_wb_sext", 8'(bus.SignExtend), 8'd0);
        bus.Opcode = 6'b000100;
        cyc();

        // BEQ: 0,1,10
        cyc(); cyc(); settle();
        check("beq_state", 8'(bus.State), 8'd10);
        check("beq_pcwc", 8'(bus.PCWriteCond), 8'd1);
        check("beq_pcsrc", 8'(bus.PCSource), 8'd1);
        check("beq_aluop", 8'(bus.ALUOp), 8'h6);
        check("beq_pcw", 8'(bus.PCWrite), 8'd0);
        check("beq_done", 8'(bus.InstrDone), 8'd1);
        bus.Opcode = 6'b000010;
        cyc(); settle();
        check("beq_back_state", 8'(bus.State), 8'd0);

        // J: 0,1,11
        cyc(); cyc(); settle();
        check("j_state", 8'(bus.State), 8'd11);
        check("j_pcw", 8'(bus.PCWrite), 8'd1);
        check("j_pcsrc", 8'(bus.PCSource), 8'd2);
        check("j_done", 8'(bus.InstrDone), 8'd1);
        bus.Opcode = 6'b111111;
        cyc(); settle();
        check("j_back_state", 8'(bus.State), 8'd0);

        // Illegal opcode.
        cyc(); settle();
        check("ill_dec_state", 8'(bus.State), 8'd1);
`ifdef MC_ILLEGAL_TRAP_EN
        check("ill_dec_done", 8'(bus.InstrDone), 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            check("trap_state", 8'(bus.State), 8'd12);
            check_no_enables("trap");
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        settle();
        check("trap_rst_state", 8'(bus.State), 8'd0);
`else
        check("ill_dec_done", 8'(bus.InstrDone), 8'd1);
        cyc(); settle();
        check("ill_back_state", 8'(bus.State), 8'd0);
`endif

        // Watchdog: 15 stalled FETCH cycles set the sticky timeout.
        bus.Opcode   = 6'b000000;
        bus.MemReady = 1'b0;
        settle();
        check("wd_fetch_irw", 8'(bus.IRWrite), 8'd0);
        for (int i = 1; i <= 14; i++) begin
            cyc(); settle();
        end
        check("wd_14_tmo", 8'(bus.MemTimeout), 8'd0);
        check("wd_14_state", 8'(bus.State), 8'd0);
        cyc(); settle();
        check("wd_15_tmo", 8'(bus.MemTimeout), 8'd1);
        check("wd_15_state", 8'(bus.State), 8'd0);
        cyc(); settle();
        check("wd_sat_tmo", 8'(bus.MemTimeout), 8'd1);
        bus.MemReady = 1'b1;
        cyc(); settle();
        check("wd_after_state", 8'(bus.State), 8'd1);
        check("wd_after_tmo", 8'(bus.MemTimeout), 8'd1);
        cyc(); cyc(); settle();
        check("wd_sticky_tmo", 8'(bus.MemTimeout), 8'd1);

        // Reset clears the sticky flag.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        settle();
        check("wd_rst_tmo", 8'(bus.MemTimeout), 8'd0);
        check("wd_rst_state", 8'(bus.State), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style main control FSM for the multi-cycle MIPS datapath. It sequences one shared ALU, one unified instruction/data memory, the IR and the register file over 3–5 states per instruction. It supports the same opcode set as the single-cycle control: R-type, LW, SW, BEQ, J, ORI, ADDI, ADDIU, ANDI, LUI, SLTI, SLTIU, XORI. Memory accesses use a MemReady wait-state handshake, and a wait-cycle watchdog counts stalled memory cycles.

Parameters:
MEM_WAIT_MAX, 15, max consecutive un-ready memory cycles before MemTimeout sets; legal range 1..255.

Ports:
CLK  input  1  clock, rising edge.
Reset_L  input  1  synchronous active-low reset.
Opcode  input  6  IR[31:26]; valid from DECODE onward.
MemReady  input  1  memory completes current access this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load if ALU Zero (external AND).
IorD  output  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
MemRead  output  1  memory read request.
MemWrite  output  1  memory write request.
IRWrite  output  1  IR load.
MemToReg  output  1  1 = MDR to regfile; 0 = ALUOut to regfile.
RegDst  output  1  1 = rd; 0 = rt.
RegWrite  output  1  regfile write enable.
ALUSrcA  output  1  0 = PC; 1 = A register.
ALUSrcB  output  2  00 = B; 01 = constant 4; 10 = ext imm; 11 = ext imm<<2.
PCSource  output  2  00 = ALU result; 01 = ALUOut; 10 = jump target.
SignExtend  output  1  1 = sign-extend imm; 0 = zero-extend imm.
ALUOp  output  4  ALU control code.
InstrDone  output  1  one-cycle pulse on the last state of each instruction.
MemTimeout  output  1  sticky watchdog flag.
State  output  4  current state (debug).

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11, TRAP=12.
- State register updates on the rising CLK edge. If Reset_L=0 at the edge: State→FETCH, wait counter→0, MemTimeout→0. Reset mid-instruction abandons the instruction with no further writes.
- While Reset_L=0, all enables are forced to 0 combinationally: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, InstrDone. Every other output is 0 in reset.
- Any output not listed for a state is 0. ALUOp codes: ADD=0010, SUB=0110, AND=0000, OR=0001, XOR=1010, ADDU=1000, SLT=0111, SLTU=1011, LUI=1110, FUNC=1111.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite and PCWrite equal MemReady (Mealy-gated).
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, SignExtend=1, ALUOp=ADD (precomputes the branch target).
  - Next state by Opcode: LW/SW→MEMADR; R-type→REXEC; BEQ→BRANCH; J→JUMP; immediate ALU ops→IEXEC; other opcodes→see Optional Feature.
- MEMADR: ALUSrcA=1, ALUSrcB=10, SignExtend=1, ALUOp=ADD. Next: LW→MEMRD, SW→MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1, InstrDone=1. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1, held until MemReady. InstrDone=MemReady. Next on MemReady: FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=FUNC. Next: RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0, InstrDone=1. Next: FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10.
  - ALUOp / SignExtend per opcode: ORI OR/0, ADDI ADD/1, ADDIU ADDU/0, ANDI AND/0, LUI LUI/0, SLTI SLT/1, SLTIU SLTU/0, XORI XOR/0.
  - Next: IWB.
- IWB: RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1. ALUOp and SignExtend are held as in IEXEC. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, InstrDone=1. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Next: FETCH.
- Opcode is decoded combinationally in every state after DECODE; the datapath holds the IR stable, so the control does not latch it.
- Watchdog:
  - 8-bit counter, incremented each cycle in FETCH, MEMRD or MEMWR while MemReady=0.
  - Cleared when MemReady=1 or on leaving those states.
  - When the counter reaches MEM_WAIT_MAX, MemTimeout sets and stays set until reset.
  - The counter saturates at MEM_WAIT_MAX. The FSM keeps waiting.
- Latency with MemReady always 1: R-type/ALU-immediate 4 cycles, LW 5, SW 4, BEQ 3, J 3.

Optional Feature:
Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP asserts no enables and holds until reset; State=12 flags the fault.
- Undefined: an unknown opcode in DECODE goes to FETCH with InstrDone=1 in DECODE, i.e. a 2-cycle NOP. TRAP is unreachable.

Test Plan:
- Reset: Reset_L=0 over 2 edges in the middle of an LW → State=0, all enables 0 during reset. First cycle after release: MemRead=1, IorD=0.
- R-type, MemReady=1: Opcode=000000 → state sequence 0,1,6,7,0. In RWB: RegWrite=1, RegDst=1, ALUOp=1111. InstrDone high exactly in cycle 4.
- LW with 3 wait cycles: MemReady low for 3 cycles in MEMRD → stays in 3 for 4 cycles, then goes to 4 with RegWrite=1, MemToReg=1. MemTimeout stays 0.
- Immediates: ADDI → ALUOp=0010, SignExtend=1. ANDI → ALUOp=0000, SignExtend=0. In IWB: RegDst=0, RegWrite=1.
- BEQ / J: BEQ → 0,1,10 with PCWriteCond=1, PCSource=01, ALUOp=0110. J → 0,1,11 with PCWrite=1, PCSource=10.
- Watchdog and illegal opcode:
  - MemReady held 0 in FETCH for 15 cycles with MEM_WAIT_MAX=15 → MemTimeout=1 and stays 1 after MemReady returns.
  - Opcode 111111 with MC_ILLEGAL_TRAP_EN defined → State=12, held until reset.
  - Opcode 111111 without the macro → returns to 0 after DECODE.
